booth_dot_product_ctrl: RTL and testbench
=========================================

Name: booth_dot_product_ctrl

Overview:
Operand sequencer and result accumulator wrapped around the 4-bit signed Booth multiplier FSM. Buffers incoming (X,Y) pairs in a small FIFO and issues them one at a time to the multiplier with a start pulse. Sums the signed 8-bit products over VEC_LEN pairs and presents the dot product on a valid/ready output.

Parameters:
VEC_LEN, 4, operand pairs per dot product (1..16)
ACC_W, 12, signed accumulator/output width (>=8)
FIFO_DEPTH, 4, input pair FIFO entries (power of 2, >=2)
TIMEOUT, 16, max cycles in WAIT without mul_valid before abort

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair present
in_ready  out  1  FIFO can accept a pair; = !full && !rst
in_x  in  4  signed multiplicand
in_y  in  4  signed multiplier
mul_start  out  1  one-cycle start pulse to multiplier
mul_x  out  4  signed X to multiplier; held stable from start until mul_valid
mul_y  out  4  signed Y to multiplier; same hold rule
mul_valid  in  1  multiplier product-valid pulse
mul_z  in  8  signed product from multiplier
out_valid  out  1  dot product available
out_ready  in  1  consumer accepts result
out_acc  out  ACC_W  signed dot product
out_sat  out  1  accumulator saturated during this vector
out_err  out  1  vector aborted by timeout
busy  out  1  state != ISSUE or FIFO non-empty

Behaviour:
- Reset (rst=1 at edge): state=ISSUE; FIFO emptied; acc=0, elem_cnt=0, wdog=0; mul_start=0, mul_x=mul_y=0, out_valid=0, out_acc=0, out_sat=0, out_err=0. Multiplier must be reset in the same cycle.
- FIFO: push when in_valid && in_ready; pop only in ISSUE. Push and pop in the same cycle is allowed when not full; occupancy unchanged. No push when full (in_ready=0). Pointers wrap modulo FIFO_DEPTH.
- States: ISSUE, WAIT, OUT.
- ISSUE: if FIFO non-empty: pop head, register mul_x/mul_y, assert mul_start for exactly one cycle, wdog=0, go to WAIT. If empty: stay, mul_start=0.
- WAIT: mul_start=0 and mul_x/mul_y held.
  - On mul_valid: acc_next = acc + sign-extended mul_z, saturating to the ACC_W signed range; set the sticky sat flag if clamped. elem_cnt++.
  - If elem_cnt was VEC_LEN-1, go to OUT; else go to ISSUE.
  - Otherwise wdog++. When wdog reaches TIMEOUT-1 with no mul_valid, set err and go to OUT with the partial acc.
- OUT: out_valid=1; out_acc/out_sat/out_err registered and stable until handshake. No mul_start is issued. FIFO keeps accepting pushes.
  - On out_valid && out_ready: clear acc, elem_cnt, sat, err; go to ISSUE.
  - out_valid drops the cycle after the handshake.
- mul_valid outside WAIT is ignored; it does not alter acc.
- Throughput: the next mul_start is asserted no earlier than 1 cycle after mul_valid. Start-to-start interval is multiplier latency + 2 cycles.
- Arithmetic: products lie in -56..64. With defaults, no saturation is possible for VEC_LEN<=16. Saturation bounds are -2^(ACC_W-1) and 2^(ACC_W-1)-1.
- Reset mid-operation takes priority over all events, including a same-cycle push, mul_valid, or output handshake.

Test Plan:
- Basic: VEC_LEN=4, push (3,2),(-4,5),(7,7),(-8,-8), out_ready=1 -> products 6,-20,49,64; out_acc=99, out_sat=0, out_err=0. Exactly 4 mul_start pulses; mul_x/mul_y stable during each WAIT.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid while pushing 5 more pairs -> out_acc held at 99; no mul_start; in_ready=0 after 4 pushes (FIFO full). Release -> handshake, then next vector starts from the FIFO.
- Saturation: ACC_W=8, push four (-8,-8) -> running sums 64, then clamp at 127; out_acc=127, out_sat=1. The following vector (1,1)x4 -> out_acc=4, out_sat=0.
- Timeout: TIMEOUT=16, replace the multiplier with a stub that returns mul_valid only for the first pair of (2,3),(1,1),... -> after 16 WAIT cycles, out_valid with out_acc=6, out_err=1. A late mul_valid in OUT leaves out_acc=6.
- Reset mid-WAIT: assert rst for 1 cycle during the second product's WAIT -> next cycle all outputs 0, in_ready=1, FIFO empty. A stray mul_valid afterwards does not change acc; a fresh vector gives the correct sum.
- FIFO concurrency: with occupancy 3 in ISSUE, push and pop in the same cycle -> occupancy stays 3, pair order preserved across pointer wrap (verified via the mul_x/mul_y sequence).

Source files
------------

// File: rtl/booth_dot_product_ctrl.sv
// booth_dot_product_ctrl: operand FIFO, Booth multiplier sequencer
// and saturating dot-product accumulator with valid/ready output.
module booth_dot_product_ctrl #(
  parameter int VEC_LEN    = 4,
  parameter int ACC_W      = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_x,
  input  logic [3:0]       in_y,
  output logic             mul_start,
  output logic [3:0]       mul_x,
  output logic [3:0]       mul_y,
  input  logic             mul_valid,
  input  logic [7:0]       mul_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat,
  output logic             out_err,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = $clog2(VEC_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [3:0]       fifo_x [FIFO_DEPTH];
  logic [3:0]       fifo_y [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [ACC_W-1:0] acc;
  logic             sat;
  logic [EW-1:0]    elem_cnt;
  logic [WW-1:0]    wdog;

  logic             full, empty;
  logic             push, pop;
  logic             last, expire;
  logic [ACC_W:0]   sum_w;
  logic [ACC_W-1:0] acc_sum;
  logic             clamp;

  assign full   = (count == CW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign push   = in_valid && in_ready;
  assign pop    = (state == S_ISSUE) && !empty;
  assign last   = (elem_cnt == EW'(VEC_LEN - 1));
  assign expire = (wdog == WW'(TIMEOUT - 1));

  // Widened add: overflow shows up as a sign mismatch in the top bits.
  always_comb begin
    sum_w   = {acc[ACC_W-1], acc}
            + {{(ACC_W-7){mul_z[7]}}, mul_z};
    acc_sum = sum_w[ACC_W-1:0];
    clamp   = 1'b0;
    if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
      clamp   = 1'b1;
      acc_sum = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_ISSUE;
    else     state <= state_nxt;
  end

  // Next-state: issue a pair, wait for product or timeout, present result.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_ISSUE: if (!empty) state_nxt = S_WAIT;
      S_WAIT: begin
        if (mul_valid)   state_nxt = last ? S_OUT : S_ISSUE;
        else if (expire) state_nxt = S_OUT;
      end
      S_OUT:   if (out_ready) state_nxt = S_ISSUE;
      default: state_nxt = S_ISSUE;
    endcase
  end

  // Output decode from the current state and FIFO level.
  always_comb begin
    out_valid = (state == S_OUT);
    busy      = (state != S_ISSUE) || !empty;
    in_ready  = !full && !rst;
  end

  // FIFO storage; push is already gated off during reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x[wr_ptr] <= in_x;
      fifo_y[wr_ptr] <= in_y;
    end
  end

  // Pointers, issue registers, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mul_start <= 1'b0;
      mul_x     <= '0;
      mul_y     <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      elem_cnt  <= '0;
      wdog      <= '0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      mul_start <= pop;
      if (pop) begin
        mul_x <= fifo_x[rd_ptr];
        mul_y <= fifo_y[rd_ptr];
        wdog  <= '0;
      end

      if (state == S_WAIT) begin
        if (mul_valid) begin
          acc      <= acc_sum;
          sat      <= sat | clamp;
          elem_cnt <= elem_cnt + 1'b1;
          if (last) begin
            out_acc <= acc_sum;
            out_sat <= sat | clamp;
            out_err <= 1'b0;
          end
        end else if (expire) begin
          out_acc <= acc;
          out_sat <= sat;
          out_err <= 1'b1;
        end else begin
          wdog <= wdog + 1'b1;
        end
      end

      if (state == S_OUT && out_ready) begin
        acc      <= '0;
        sat      <= 1'b0;
        elem_cnt <= '0;
        out_sat  <= 1'b0;
        out_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_dot_product_ctrl.sv
// tb_booth_dot_product_ctrl: randomized scoreboard bench with a
// behavioural multiplier stub and a pair-stream reference model.
module tb_booth_dot_product_ctrl;

  localparam int VEC_LEN    = 4;
  localparam int ACC_W      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;
  localparam int MAXV = (1 << (ACC_W - 1)) - 1;
  localparam int MINV = -(1 << (ACC_W - 1));

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_x = '0;
  logic [3:0]       in_y = '0;
  logic             mul_start;
  logic [3:0]       mul_x, mul_y;
  logic             mul_valid = 1'b0;
  logic [7:0]       mul_z = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_acc;
  logic             out_sat, out_err, busy;

  booth_dot_product_ctrl #(
    .VEC_LEN(VEC_LEN), .ACC_W(ACC_W),
    .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_valid(mul_valid), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_sat(out_sat), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; bit drop; } pair_t;
  typedef struct { int acc; bit sat; bit err; } res_t;

  pair_t iss_q[$];
  res_t  exp_q[$];

  int compared   = 0;
  int mismatched = 0;
  int starts     = 0;
  bit hold_ready = 1'b0;
  bit stray_req  = 1'b0;
  int fix_lat    = 0;
  int m_acc      = 0;
  int m_cnt      = 0;
  bit m_sat      = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Reference: dot products of the accepted pair stream, clamped
  // at every step; a dropped pair closes its vector with err set.
  task automatic model_push(input int x, input int y, input bit drop);
    int s;
    if (drop) begin
      exp_q.push_back('{m_acc, m_sat, 1'b1});
      m_acc = 0; m_cnt = 0; m_sat = 1'b0;
    end else begin
      s = m_acc + x * y;
      if (s > MAXV) begin s = MAXV; m_sat = 1'b1; end
      if (s < MINV) begin s = MINV; m_sat = 1'b1; end
      m_acc = s;
      m_cnt++;
      if (m_cnt == VEC_LEN) begin
        exp_q.push_back('{m_acc, m_sat, 1'b0});
        m_acc = 0; m_cnt = 0; m_sat = 1'b0;
      end
    end
  endtask

  task automatic push(input int x, input int y, input bit drop);
    int n;
    n = 0;
    in_x = x[3:0];
    in_y = y[3:0];
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("push_accept", int'(in_ready), 1);
      in_valid = 1'b0;
    end else begin
      iss_q.push_back('{x, y, drop});
      model_push(x, y, drop);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  function automatic int rnd4();
    return int'($urandom_range(0, 15)) - 8;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || iss_q.size() != 0 || busy)
           && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", int'(n < 3000), 1);
  endtask

  task automatic wait_starts(input int target);
    int n;
    n = 0;
    while (starts < target && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("start_seen", int'(starts >= target), 1);
  endtask

  // Consumer readiness, random unless a test holds it low.
  initial forever begin
    @(posedge clk); #2;
    out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Multiplier stub: checks issued operands, answers after a
  // random latency, and injects stray product pulses when idle.
  initial begin : stub
    bit    pending;
    bit    prev_start;
    int    cd, px, py, p;
    pair_t cur;
    pending = 1'b0; prev_start = 1'b0;
    cd = 0; px = 0; py = 0; p = 0;
    forever begin
      @(negedge clk);
      mul_valid = 1'b0;
      if (rst) begin
        pending = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (mul_start) begin
          starts++;
          chk("start_width", int'(prev_start), 0);
          chk("start_in_out", int'(out_valid), 0);
          chk("start_expected", int'(iss_q.size() > 0), 1);
          if (iss_q.size() > 0) begin
            cur = iss_q.pop_front();
            chk("mul_x", int'($signed(mul_x)), cur.x);
            chk("mul_y", int'($signed(mul_y)), cur.y);
            if (!cur.drop) begin
              pending = 1'b1;
              cd = (fix_lat > 0) ? fix_lat
                                 : int'($urandom_range(1, 4));
              px = cur.x;
              py = cur.y;
            end
          end
        end else if (pending) begin
          chk("mul_x_hold", int'($signed(mul_x)), px);
          chk("mul_y_hold", int'($signed(mul_y)), py);
          cd--;
          if (cd == 0) begin
            p = px * py;
            mul_z = p[7:0];
            mul_valid = 1'b1;
            pending = 1'b0;
          end
        end else if ((stray_req || $urandom_range(0, 7) == 0) &&
                     (!busy || (out_valid && !out_ready))) begin
          mul_z = 8'($urandom);
          mul_valid = 1'b1;
          stray_req = 1'b0;
        end
        prev_start = mul_start;
      end
    end
  end

  // Monitor: compare every presented result against the scoreboard.
  initial begin : monitor
    bit   hs_prev;
    res_t e;
    hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs_prev = 1'b0;
      end else begin
        if (hs_prev) chk("out_valid_drop", int'(out_valid), 0);
        hs_prev = 1'b0;
        if (out_valid) begin
          chk("result_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("out_acc", int'($signed(out_acc)), e.acc);
            chk("out_sat", int'(out_sat), int'(e.sat));
            chk("out_err", int'(out_err), int'(e.err));
            if (out_ready) begin
              e = exp_q.pop_front();
              hs_prev = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int s0, n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("init_in_ready", int'(in_ready), 1);
    chk("init_out_acc", int'(out_acc), 0);
    chk("init_out_sat", int'(out_sat), 0);
    chk("init_out_err", int'(out_err), 0);
    chk("init_mul_start", int'(mul_start), 0);
    chk("init_mul_x", int'(mul_x), 0);

    // Basic vector: 6 - 20 + 49 + 64 = 99.
    s0 = starts;
    push(3, 2, 0); push(-4, 5, 0); push(7, 7, 0); push(-8, -8, 0);
    drain();
    chk("basic_starts", starts - s0, 4);

    // Backpressure: result held while the FIFO fills.
    hold_ready = 1'b1;
    push(3, 2, 0); push(-4, 5, 0); push(7, 7, 0); push(-8, -8, 0);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("bp_out_valid", int'(out_valid), 1);
    s0 = starts;
    repeat (4) push(rnd4(), rnd4(), 0);
    chk("bp_in_ready_full", int'(in_ready), 0);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_hold_acc", int'($signed(out_acc)), 99);
    end
    chk("bp_no_start", starts - s0, 0);
    hold_ready = 1'b0;
    repeat (4) push(rnd4(), rnd4(), 0);
    drain();

    // Saturation in both directions, then a clean vector.
    repeat (4) push(-8, -8, 0);
    repeat (4) push(1, 1, 0);
    repeat (4) push(7, -8, 0);
    drain();

    // Timeout after the second pair; stray product in OUT.
    hold_ready = 1'b1;
    s0 = starts;
    push(2, 3, 0); push(1, 1, 1);
    wait_starts(s0 + 2);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("timeout_cycles", n, TIMEOUT - 1);
    chk("timeout_err", int'(out_err), 1);
    stray_req = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("stray_issued", int'(stray_req), 0);
    chk("late_valid_acc", int'($signed(out_acc)), 6);
    hold_ready = 1'b0;
    repeat (4) push(1, 1, 0);
    drain();

    // Randomized stream with idle gaps and occasional dropped pairs.
    for (int i = 0; i < 48; i++) begin
      push(rnd4(), rnd4(), $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    while (m_cnt != 0) push(rnd4(), rnd4(), 0);
    drain();

    // Reset during the second product's wait.
    fix_lat = 4;
    s0 = starts;
    push(3, 2, 0); push(-4, 5, 0);
    wait_starts(s0 + 2);
    rst = 1'b1;
    iss_q.delete();
    exp_q.delete();
    m_acc = 0; m_cnt = 0; m_sat = 1'b0;
    @(posedge clk); #1;
    chk("mrst_in_ready", int'(in_ready), 0);
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_out_acc", int'(out_acc), 0);
    chk("mrst_mul_start", int'(mul_start), 0);
    rst = 1'b0;
    fix_lat = 0;
    @(posedge clk); #1;
    chk("mrst_in_ready_rel", int'(in_ready), 1);
    chk("mrst_mul_y", int'(mul_y), 0);
    stray_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("mrst_stray_issued", int'(stray_req), 0);
    push(5, 5, 0); push(-3, 7, 0); push(2, -2, 0); push(1, 6, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
